fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter DATA_LENGTH, default 32, instruction width.
REQ-002 The block SHALL have parameter PC_WIDTH, default 32, address width.
REQ-003 The block SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port imem_req_valid  output  1  instruction-memory request valid.
REQ-007 The block SHALL have port imem_req_ready  input  1  memory accepts the request.
REQ-008 The block SHALL have port imem_req_addr  output  PC_WIDTH  request address.
REQ-009 The block SHALL have port imem_rsp_valid  input  1  response data valid.
REQ-010 The block SHALL have port imem_rsp_data  input  DATA_LENGTH  fetched instruction.
REQ-011 The block SHALL have port stall  input  1  decode-side register enable is low; hold outputs.
REQ-012 The block SHALL have port redirect_valid  input  1  branch/jump taken; refetch.
REQ-013 The block SHALL have port redirect_pc  input  PC_WIDTH  redirect target.
REQ-014 The block SHALL have ports ins_out (DATA_LENGTH), pc_out (PC_WIDTH), pc_plus4_out (PC_WIDTH) and ins_valid (1), all outputs, forming the fetch-to-decode bundle.

Function
REQ-015 The block SHALL allow at most one outstanding memory request.
REQ-016 The FSM SHALL have states IDLE, REQ, WAIT and HOLD; rst forces IDLE.
REQ-017 IDLE SHALL go to REQ on the next edge unconditionally.
REQ-018 REQ SHALL assert imem_req_valid with imem_req_addr = pc_q, and SHALL go to WAIT on the edge where imem_req_ready=1.
REQ-019 imem_req_valid and imem_req_addr SHALL stay stable in REQ until accepted.
REQ-020 In WAIT, an imem_rsp_valid SHALL load ins_out=imem_rsp_data, pc_out=pc_q, pc_plus4_out=pc_q+4 (modulo 2^PC_WIDTH) and ins_valid=1, and SHALL set pc_q to pc_q+4.
REQ-021 After that load, the FSM SHALL go to REQ if stall=0, else to HOLD.
REQ-022 HOLD SHALL keep all outputs unchanged and SHALL go to REQ on the first edge with stall=0.
REQ-023 When stall=0 and no new response is loaded, ins_valid SHALL clear to 0 on the edge after the bundle is consumed.
REQ-024 Fetch latency SHALL be request acceptance plus one cycle: the response in cycle N appears on the outputs in cycle N+1.
REQ-025 redirect_valid=1 SHALL set pc_q to redirect_pc and clear ins_valid in every state; redirect SHALL take priority over stall and over a simultaneous response.
REQ-026 A redirect in REQ before acceptance SHALL update imem_req_addr to redirect_pc on the next cycle.
REQ-027 A redirect in WAIT SHALL set a drop flag; the pending response SHALL then be discarded without updating outputs or pc_q, after which the FSM SHALL go to REQ.
REQ-028 A redirect in HOLD SHALL move the FSM to REQ regardless of stall.
REQ-029 A stall in REQ or WAIT SHALL NOT block request issue or response capture; only the transition out of the response is gated (REQ-021).

Reset
REQ-030 While rst=1, the block SHALL hold: state=IDLE; pc_q=RESET_PC; imem_req_valid=0; imem_req_addr=RESET_PC; ins_out=0; pc_out=0; pc_plus4_out=0; ins_valid=0; drop flag=0.
REQ-031 Reset asserted mid-request SHALL abandon the request; any later imem_rsp_valid SHALL be ignored until a new request is accepted.

Configuration
REQ-032 With macro FETCH_BUBBLE_NOP_EN defined, ins_out SHALL read 32'h0000_0013 (addi x0,x0,0) whenever ins_valid=0, including during reset; without it, ins_out SHALL hold its last value (0 after reset).

Verification
REQ-033 Reset release, ready=1, 1-cycle response 0x00500093: req addr 0x0 -> ins_out=0x00500093, pc_out=0, pc_plus4_out=4, ins_valid=1; next req addr=0x4.
REQ-034 stall=1 for 3 cycles while a bundle at pc 0x8 is held -> outputs stable for 3 cycles; next request is 0xC one cycle after stall drops.
REQ-035 redirect_valid=1 with redirect_pc=0x100 in WAIT; response arrives -> response dropped, ins_valid=0, next req addr=0x100.
REQ-036 redirect and imem_rsp_valid in the same cycle -> redirect wins; next req addr=redirect_pc; outputs not loaded.
REQ-037 imem_req_ready held 0 for 4 cycles -> req_valid=1 and addr stable throughout; single acceptance only.
REQ-038 pc_q=0xFFFF_FFFC with a response -> pc_plus4_out=0x0000_0000 (wrap), next req addr=0x0.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: walks the program counter, issues one request at a
// time to instruction memory and registers each returned instruction into the
// fetch-to-decode bundle.
//
// Parameters
//   DATA_LENGTH  instruction width
//   PC_WIDTH     address width
//   RESET_PC     first fetch address
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   imem_req_valid/ready/addr   request channel to instruction memory
//   imem_rsp_valid/data         response channel (no backpressure)
//   stall                       decode cannot take a new bundle
//   redirect_valid/redirect_pc  taken branch/jump, refetch from redirect_pc
//   ins_out, pc_out,
//   pc_plus4_out, ins_valid     fetch-to-decode bundle
//   state_dbg                   current FSM state (IDLE=0 REQ=1 WAIT=2 HOLD=3)
//
// Handshake: a request transfers on a rising edge where imem_req_valid and
// imem_req_ready are both 1; until then valid and addr stay stable unless a
// redirect retargets the request. A response transfers on any edge with
// imem_rsp_valid=1 while a request is outstanding; at most one request is
// ever outstanding.
//
// Build option: define FETCH_BUBBLE_NOP_EN to present addi x0,x0,0 on ins_out
// whenever ins_valid is 0; otherwise ins_out holds its last loaded value.
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter int                  DATA_LENGTH = 32,
   parameter int                  PC_WIDTH    = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   imem_req_valid,
   input  logic                   imem_req_ready,
   output logic [PC_WIDTH-1:0]    imem_req_addr,
   input  logic                   imem_rsp_valid,
   input  logic [DATA_LENGTH-1:0] imem_rsp_data,
   input  logic                   stall,
   input  logic                   redirect_valid,
   input  logic [PC_WIDTH-1:0]    redirect_pc,
   output logic [DATA_LENGTH-1:0] ins_out,
   output logic [PC_WIDTH-1:0]    pc_out,
   output logic [PC_WIDTH-1:0]    pc_plus4_out,
   output logic                   ins_valid,
   output logic [1:0]             state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d, pc_inc;
   logic                   drop_q, drop_d;
   logic                   iv_q, iv_d;
   logic                   load;
   logic [DATA_LENGTH-1:0] ins_q;
   logic [PC_WIDTH-1:0]    pc_out_q, pc4_q;

   // Wraps naturally modulo 2^PC_WIDTH.
   assign pc_inc = pc_q + PC_WIDTH'(4);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      drop_d  = drop_q;
      load    = 1'b0;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (imem_req_ready) begin
               state_d = WAIT;
               // Accepted with the pre-redirect address: its response is stale.
               if (redirect_valid) drop_d = 1'b1;
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               drop_d = 1'b0;
               if (drop_q || redirect_valid) begin
                  state_d = REQ;
               end else begin
                  load    = 1'b1;
                  pc_d    = pc_inc;
                  state_d = stall ? HOLD : REQ;
               end
            end else if (redirect_valid) begin
               drop_d = 1'b1;
            end
         end
         HOLD: begin
            if (!stall || redirect_valid) state_d = REQ;
         end
         default: state_d = IDLE;
      endcase
      if (redirect_valid) pc_d = redirect_pc;

      // Bundle valid: flushed by redirect, set by a load, otherwise kept only
      // while decode is stalled (an unstalled edge consumes it).
      if (redirect_valid)  iv_d = 1'b0;
      else if (load)       iv_d = 1'b1;
      else if (stall)      iv_d = iv_q;
      else                 iv_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         drop_q   <= 1'b0;
         iv_q     <= 1'b0;
         ins_q    <= '0;
         pc_out_q <= '0;
         pc4_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         drop_q  <= drop_d;
         iv_q    <= iv_d;
         if (load) begin
            ins_q    <= imem_rsp_data;
            pc_out_q <= pc_q;
            pc4_q    <= pc_inc;
         end
      end
   end

   assign imem_req_valid = (state_q == REQ);
   assign imem_req_addr  = pc_q;
   assign pc_out         = pc_out_q;
   assign pc_plus4_out   = pc4_q;
   assign ins_valid      = iv_q;
   assign state_dbg      = state_q;

`ifdef FETCH_BUBBLE_NOP_EN
   localparam logic [DATA_LENGTH-1:0] NOP_INS = DATA_LENGTH'(32'h0000_0013);
   assign ins_out = iv_q ? ins_q : NOP_INS;
`else
   assign ins_out = ins_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BUBBLE_NOP_EN
   localparam logic [31:0] RST_INS = 32'h0000_0013;
`else
   localparam logic [31:0] RST_INS = 32'h0000_0000;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] ins_out, pc_out, pc_plus4_out;
   logic        ins_valid;
   logic [1:0]  state_dbg;

   always #5 clk = ~clk;

   fetch_unit #(.DATA_LENGTH(32), .PC_WIDTH(32), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .ins_out(ins_out), .pc_out(pc_out), .pc_plus4_out(pc_plus4_out),
      .ins_valid(ins_valid), .state_dbg(state_dbg)
   );

   // ---------------- scoreboard state ----------------
   // Entry: {cycle issued, instruction, pc, pc+4}
   logic [127:0] exp_q[$];
   int           total = 0;
   int           bad   = 0;
   int           cyc   = 0;
   bit           hung  = 1'b0;

   // Reference model: program-order fetch address and the one outstanding request.
   logic [31:0]  exp_pc = RESET_PC;
   logic [31:0]  acc_pc = '0;
   bit           outstanding = 1'b0;
   bit           killed = 1'b0;
   int           idle_cnt = 0;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      outstanding = 1'b0;
      killed      = 1'b0;
      exp_pc      = RESET_PC;
      idle_cnt    = 0;
      exp_q.delete();
   endtask

   // ---------------- driver ----------------
   // One clock cycle of stimulus; memory side reacts to the DUT's request.
   task automatic step(input logic s, input logic rv, input logic [31:0] rp,
                       input logic rdy, input logic rsp_en, input logic [31:0] data,
                       input logic frc);
      bit rsp_hit;
      @(posedge clk);
      #1;
      cyc++;
      rsp_hit        = rsp_en & outstanding;
      stall          = s;
      redirect_valid = rv;
      redirect_pc    = rp;
      imem_req_ready = rdy & ~rv;
      imem_rsp_valid = rsp_hit | frc;
      imem_rsp_data  = data;
      if (!rst) begin
         chk("single_outstanding", 160'(imem_req_valid & outstanding), 160'(0));
         if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", 160'(imem_req_addr), 160'(exp_pc));
            outstanding = 1'b1;
            killed      = 1'b0;
            acc_pc      = exp_pc;
            idle_cnt    = 0;
         end
         if (rsp_hit) begin
            outstanding = 1'b0;
            if (!killed && !rv) begin
               exp_q.push_back({32'(cyc), data, acc_pc, acc_pc + 32'd4});
               exp_pc = acc_pc + 32'd4;
            end
         end
         if (rv) begin
            exp_pc = rp;
            if (outstanding) killed = 1'b1;
         end
         idle_cnt++;
         if (idle_cnt > 64 && !hung) begin
            total++;
            bad++;
            hung = 1'b1;
            $display("FAIL progress: got no request acceptance in %0d cycles expected one", idle_cnt);
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) step(0, 0, 0, 0, 0, 0, 0);
      model_reset();
      rst = 1'b0;
   endtask

   // Issue one fetch: wait for acceptance, then respond the following cycle.
   task automatic fetch(input logic s_rsp, input logic [31:0] data, output int n);
      n = 0;
      do begin
         step(0, 0, 0, 1, 0, 0, 0);
         n++;
      end while (!outstanding && n < 20 && !hung);
      step(s_rsp, 0, 0, 0, 1, data, 0);
   endtask

   // ---------------- monitor ----------------
   logic        p_iv = 0, p_stall = 0, p_rv = 0, p_req_v = 0, p_ready = 0;
   logic [31:0] p_ins = 0, p_pc = 0, p_pc4 = 0, p_addr = 0, p_rpc = 0;

   always @(negedge clk) begin
      logic [127:0] e;
      if (rst) begin
         chk("reset_out",
             160'({imem_req_valid, imem_req_addr, ins_valid, ins_out, pc_out, pc_plus4_out}),
             160'({1'b0, RESET_PC, 1'b0, RST_INS, 32'h0, 32'h0}));
         p_iv = 0; p_stall = 0; p_rv = 0; p_req_v = 0; p_ready = 0;
      end else begin
         if (exp_q.size() > 0 && exp_q[0][127:96] != 32'(cyc)) begin
            e = exp_q.pop_front();
            chk("bundle", 160'({ins_valid, ins_out, pc_out, pc_plus4_out}),
                160'({1'b1, e[95:0]}));
         end else if (p_rv) begin
            chk("flush", 160'(ins_valid), 160'(0));
         end else if (p_stall && p_iv) begin
            chk("hold", 160'({ins_valid, ins_out, pc_out, pc_plus4_out}),
                160'({p_iv, p_ins, p_pc, p_pc4}));
         end else begin
            chk("consume_clear", 160'(ins_valid), 160'(0));
         end
`ifdef FETCH_BUBBLE_NOP_EN
         if (!ins_valid) chk("bubble_nop", 160'(ins_out), 160'(32'h0000_0013));
`endif
         if (p_req_v && p_rv)
            chk("req_redirect", 160'({imem_req_valid, imem_req_addr}), 160'({1'b1, p_rpc}));
         else if (p_req_v && !p_ready)
            chk("req_stable", 160'({imem_req_valid, imem_req_addr}), 160'({1'b1, p_addr}));
         p_iv = ins_valid; p_ins = ins_out; p_pc = pc_out; p_pc4 = pc_plus4_out;
         p_stall = stall; p_rv = redirect_valid; p_rpc = redirect_pc;
         p_req_v = imem_req_valid; p_ready = imem_req_ready; p_addr = imem_req_addr;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      logic s, rv, rdy, rsp;
      logic [31:0] rp;

      do_reset();

      // First fetch from reset, then a normal one.
      fetch(0, 32'h0050_0093, n);
      fetch(0, 32'h0011_0113, n);
      // Bundle at pc 0x8 held for three stalled cycles.
      fetch(1, 32'h0021_8193, n);
      repeat (3) step(1, 0, 0, 0, 0, 0, 0);
      fetch(0, 32'h0032_0213, n);
      chk("req_after_stall", 160'(n), 160'(2));

      // Redirect while waiting; the later response must be dropped.
      step(0, 0, 0, 1, 0, 0, 0);
      step(0, 1, 32'h0000_0100, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0);
      fetch(0, 32'h0042_8293, n);

      // Redirect and response in the same cycle.
      step(0, 0, 0, 1, 0, 0, 0);
      step(0, 1, 32'h0000_0200, 0, 1, 32'hBAD0_BAD0, 0);
      // Memory not ready for four cycles.
      repeat (4) step(0, 0, 0, 0, 0, 0, 0);
      fetch(0, 32'h0053_0313, n);

      // Redirect while requesting, to the top of the address space.
      step(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
      fetch(0, 32'h0063_8393, n);
      fetch(0, 32'h0074_0413, n);

      // Reset while a request is outstanding; stray responses afterwards.
      step(0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      do_reset();
      repeat (3) step(0, 0, 0, 0, 0, 32'hFEED_F00D, 1);
      fetch(0, 32'h0084_8493, n);

      // Randomized traffic.
      for (int i = 0; i < 1500 && !hung; i++) begin
         s   = ($urandom_range(0, 3) == 0);
         rv  = ($urandom_range(0, 11) == 0);
         rp  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
         rdy = ($urandom_range(0, 2) != 0);
         rsp = ($urandom_range(0, 1) == 0);
         step(s, rv, rp, rdy, rsp, $urandom, 0);
      end
      repeat (4) step(0, 0, 0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
